ad9516_spi_cfg: RTL

Configuration sequencer for one AD9516 clock generator on the VPX control board. On `start_i` it pulses the chip reset, streams a register table over 3-wire-style SPI (write-only, SDI), issues the IO-update write, then qualifies PLL lock detect with a timeout. It drives the `ad9516_N_*` pins of `vpx_brd_ctrl_core`; the core instantiates two copies, one per AD9516, each with its own register table.

---
 rtl/ad9516_spi_cfg_if.sv | 36 +++
 rtl/ad9516_spi_cfg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad9516_spi_cfg_if.sv
// ad9516_spi_cfg_if
//   Pin bundle between one AD9516 configuration sequencer and the board side
//   (register table ROM, AD9516 control/SPI pins, status flags).
//   master : the sequencer (drives SPI pins, chip control, table index, flags)
//   slave  : the board side (drives start, table contents, lock detect)
interface ad9516_spi_cfg_if #(
  parameter int IDX_W = 6
);
  logic             start_i;
  logic [IDX_W-1:0] tbl_idx_o;
  logic [9:0]       tbl_addr_i;
  logic [7:0]       tbl_data_i;
  logic             clock_reset_o;
  logic             cs_o;
  logic             sclk_o;
  logic             sdi_o;
  logic             pd_o;
  logic             refsel_o;
  logic             ld_i;
  logic             busy_o;
  logic             done_o;
  logic             locked_o;
  logic             timeout_o;

  modport master (
    input  start_i, tbl_addr_i, tbl_data_i, ld_i,
    output tbl_idx_o, clock_reset_o, cs_o, sclk_o, sdi_o, pd_o, refsel_o,
    output busy_o, done_o, locked_o, timeout_o
  );

  modport slave (
    output start_i, tbl_addr_i, tbl_data_i, ld_i,
    input  tbl_idx_o, clock_reset_o, cs_o, sclk_o, sdi_o, pd_o, refsel_o,
    input  busy_o, done_o, locked_o, timeout_o
  );
endinterface

// File: rtl/ad9516_spi_cfg.sv
// ad9516_spi_cfg
//   Configuration sequencer for one AD9516 clock generator. On start it pulses
//   the chip reset, writes TBL_LEN register table entries over write-only SPI,
//   issues the IO-update write (0x232 <= 0x01), then qualifies PLL lock detect
//   (16 consecutive synced high samples) against a timeout.
// Ports:
//   main_100mhz_clk_i : system clock (only clock)
//   fpga_rst_i        : asynchronous active-high reset
//   bus (master)      : start, table index/addr/data, chip RESET/PD/REFSEL,
//                       SPI cs/sclk/sdi, lock detect, busy/done/locked/timeout
// Every output is registered.
module ad9516_spi_cfg #(
  parameter int CLK_DIV      = 10,
  parameter int TBL_LEN      = 60,
  parameter int IDX_W        = 6,
  parameter int RST_CYCLES   = 1000,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter bit REFSEL       = 1'b0
) (
  input logic               main_100mhz_clk_i,
  input logic               fpga_rst_i,
  ad9516_spi_cfg_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_LOW, S_RST_WAIT, S_FETCH, S_FRAME,
    S_GAP, S_IOUPD, S_LOCK_WAIT, S_DONE, S_FAIL
  } state_t;

  // A frame is 50 half-periods of SCLK: one low lead-in half, 24 bits of
  // (high, low), and one trailing half with cs still low.
  localparam logic [5:0] LAST_HALF       = 6'd49;
  localparam logic [5:0] LAST_RISE_HALF  = 6'd46;  // half before the 24th rise
  localparam logic [5:0] LAST_FALL_HALF  = 6'd47;  // half before the 24th fall
  localparam logic [5:0] LAST_SHIFT_HALF = 6'd45;  // no new bit after 24th fall
  localparam int         LOCK_QUAL       = 16;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TBL_LEN - 1);

  function automatic logic [23:0] build_frame(input logic [9:0] addr,
                                              input logic [7:0] data);
    // write command, 1-byte transfer, then 13-bit address field and data
    return {1'b0, 2'b00, 3'b000, addr, data};
  endfunction

  state_t           state;
  logic [31:0]      cnt;
  logic [15:0]      div_cnt;
  logic [5:0]       half;
  logic [22:0]      shreg;
  logic             is_io;
  logic             last_ent;
  logic [IDX_W-1:0] idx;
  logic             clock_reset;
  logic             cs;
  logic             sclk;
  logic             sdi;
  logic             busy;
  logic             done;
  logic             locked;
  logic             timeout;
  logic             ld_s1;
  logic             ld_s2;
  logic [4:0]       qual;

  logic             start_ok;
  logic             qual_hit;
  logic [23:0]      frame_w;

  assign start_ok = bus.start_i &&
                    (state == S_IDLE || state == S_DONE || state == S_FAIL);
  assign qual_hit = ld_s2 && (qual == 5'(LOCK_QUAL - 1));
  assign frame_w  = (state == S_IOUPD) ? build_frame(10'h232, 8'h01)
                                       : build_frame(bus.tbl_addr_i, bus.tbl_data_i);

  always_ff @(posedge main_100mhz_clk_i or posedge fpga_rst_i) begin
    if (fpga_rst_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      div_cnt     <= '0;
      half        <= '0;
      shreg       <= '0;
      is_io       <= 1'b0;
      last_ent    <= 1'b0;
      idx         <= '0;
      clock_reset <= 1'b0;
      cs          <= 1'b1;
      sclk        <= 1'b0;
      sdi         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
      ld_s1       <= 1'b0;
      ld_s2       <= 1'b0;
      qual        <= '0;
    end else begin
      ld_s1 <= bus.ld_i;
      ld_s2 <= ld_s1;

      if (start_ok) begin
        state       <= S_RST_LOW;
        cnt         <= '0;
        idx         <= '0;
        clock_reset <= 1'b0;
        busy        <= 1'b1;
        done        <= 1'b0;
        locked      <= 1'b0;
        timeout     <= 1'b0;
      end else begin
        case (state)
          S_RST_LOW: begin
            if (cnt == 32'(RST_CYCLES - 1)) begin
              cnt         <= '0;
              clock_reset <= 1'b1;
              idx         <= '0;
              state       <= S_RST_WAIT;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end

          S_RST_WAIT: begin
            if (cnt == 32'(RST_CYCLES - 1)) begin
              cnt   <= '0;
              state <= S_FETCH;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end

          S_FETCH, S_IOUPD: begin
            cs      <= 1'b0;
            sdi     <= frame_w[23];
            shreg   <= frame_w[22:0];
            div_cnt <= '0;
            half    <= '0;
            is_io   <= (state == S_IOUPD);
            state   <= S_FRAME;
          end

          S_FRAME: begin
            if (div_cnt == 16'(CLK_DIV - 1)) begin
              div_cnt <= '0;
              half    <= half + 6'd1;
              if (half == LAST_HALF) begin
                cs   <= 1'b1;
                sdi  <= 1'b0;
                sclk <= 1'b0;
                cnt  <= '0;
                qual <= '0;
                if (is_io) begin
                  state <= S_LOCK_WAIT;
                end else begin
                  // Advance the index at the start of the gap so the table's
                  // one-clock read latency is hidden before the next FETCH.
                  last_ent <= (idx == LAST_IDX);
                  if (idx != LAST_IDX) idx <= idx + 1'b1;
                  state <= S_GAP;
                end
              end else if (!half[0] && half <= LAST_RISE_HALF) begin
                sclk <= 1'b1;
              end else if (half[0] && half <= LAST_FALL_HALF) begin
                sclk <= 1'b0;
                if (half <= LAST_SHIFT_HALF) begin
                  sdi   <= shreg[22];
                  shreg <= {shreg[21:0], 1'b0};
                end
              end
            end else begin
              div_cnt <= div_cnt + 16'd1;
            end
          end

          S_GAP: begin
            if (cnt == 32'(2 * CLK_DIV - 1)) begin
              cnt   <= '0;
              state <= last_ent ? S_IOUPD : S_FETCH;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end

          S_LOCK_WAIT: begin
            if (ld_s2) qual <= qual + 5'd1;
            else       qual <= '0;
            if (qual_hit) begin
              locked <= 1'b1;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end else if (cnt == 32'(LOCK_TIMEOUT - 1)) begin
              timeout <= 1'b1;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= S_FAIL;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end

          // Once locked, the flag simply follows the synced detect.
          S_DONE: locked <= ld_s2;

          default: ;
        endcase
      end
    end
  end

  assign bus.tbl_idx_o     = idx;
  assign bus.clock_reset_o = clock_reset;
  assign bus.cs_o          = cs;
  assign bus.sclk_o        = sclk;
  assign bus.sdi_o         = sdi;
  assign bus.pd_o          = 1'b1;
  assign bus.refsel_o      = REFSEL;
  assign bus.busy_o        = busy;
  assign bus.done_o        = done;
  assign bus.locked_o      = locked;
  assign bus.timeout_o     = timeout;

endmodule
